// File: rtl/bcd_down_timer.sv
// Loadable multi-digit BCD down-counter with borrow pulse, one-shot or auto-reload, optional tick prescaler.
// Latency: load -> q one cycle; a due tick updates q on the same edge, so q is visible the following cycle.
// Backpressure: none; d=0 pauses the prescaler and count, and a load always wins over a tick.
module bcd_down_timer #(
    parameter int DIGITS   = 2,
    parameter int PRESCALE = 1,
    parameter int RELOAD   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   din,
    input  logic                  d,
    output logic [4*DIGITS-1:0]   q,
    output logic                  b,
    output logic                  busy,
    output logic                  err
);

    localparam int W  = 4 * DIGITS;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    cnt_q, cnt_d;
    logic [W-1:0]    rld_q, rld_d;
    logic [PW-1:0]   pre_q, pre_d;
    logic            b_q, b_d;
    logic            busy_q, busy_d;
    logic            err_q, err_d;
    logic            din_ok;

    // Decimal decrement: zero digits roll to 9 and pass the borrow up; the first non-zero digit absorbs it.
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // A load is accepted only when every nibble is a decimal digit.
    always_comb begin
        din_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (din[4*i +: 4] > 4'd9) begin
                din_ok = 1'b0;
            end
        end
    end

    // Next-state logic: valid load first, then prescaled ticks in RUN; a rejected load only raises err.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rld_d   = rld_q;
        pre_d   = pre_q;
        b_d     = 1'b0;
        err_d   = 1'b0;
        if (load && din_ok) begin
            cnt_d   = din;
            rld_d   = din;
            pre_d   = '0;
            state_d = (din != '0) ? RUN : DONE;
        end else begin
            if (load) begin
                err_d = 1'b1;
            end
            if (state_q == RUN && d) begin
                if (pre_q == PRE_LAST) begin
                    pre_d = '0;
                    if (cnt_q == W'(1)) begin
                        b_d = 1'b1;
                        if (RELOAD != 0) begin
                            cnt_d = rld_q;
                        end else begin
                            cnt_d   = '0;
                            state_d = DONE;
                        end
                    end else begin
                        cnt_d = bcd_dec(cnt_q);
                    end
                end else begin
                    pre_d = pre_q + PW'(1);
                end
            end
        end
        busy_d = (state_d == RUN);
    end

    // State and registered outputs; synchronous reset overrides everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rld_q   <= '0;
            pre_q   <= '0;
            b_q     <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rld_q   <= rld_d;
            pre_q   <= pre_d;
            b_q     <= b_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign q    = cnt_q;
    assign b    = b_q;
    assign busy = busy_q;
    assign err  = err_q;

endmodule

// File: tb/tb_bcd_down_timer.sv
// Bench for bcd_down_timer: one-shot/no-prescale instance and auto-reload/prescale-3 instance.
// Stimulus pushes the expected post-edge outputs; a negedge monitor pops and compares.
// Inputs change on the falling edge only.
module tb_bcd_down_timer;

    typedef struct packed {
        logic       sel;
        logic [7:0] q;
        logic       b;
        logic       busy;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst0 = 1'b1, load0 = 1'b0, d0 = 1'b0;
    logic       rst1 = 1'b1, load1 = 1'b0, d1 = 1'b0;
    logic [7:0] din0 = 8'h00, din1 = 8'h00;
    logic [7:0] q0, q1;
    logic       b0, b1, busy0, busy1, err0, err1;

    exp_t  sb[$];
    string names[$];
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    bcd_down_timer #(.DIGITS(2), .PRESCALE(1), .RELOAD(0)) dut0 (
        .clk(clk), .reset(rst0), .load(load0), .din(din0), .d(d0),
        .q(q0), .b(b0), .busy(busy0), .err(err0)
    );

    bcd_down_timer #(.DIGITS(2), .PRESCALE(3), .RELOAD(1)) dut1 (
        .clk(clk), .reset(rst1), .load(load1), .din(din1), .d(d1),
        .q(q1), .b(b1), .busy(busy1), .err(err1)
    );

    task automatic cmp(input string nm, input string fld, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
        end
    endtask

    // Monitor: every cycle with a pending expectation, compare the selected instance.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t  e;
            string nm;
            e  = sb.pop_front();
            nm = names.pop_front();
            if (e.sel == 1'b0) begin
                cmp(nm, "q", q0, e.q);
                cmp(nm, "b", {7'd0, b0}, {7'd0, e.b});
                cmp(nm, "busy", {7'd0, busy0}, {7'd0, e.busy});
                cmp(nm, "err", {7'd0, err0}, {7'd0, e.err});
            end else begin
                cmp(nm, "q", q1, e.q);
                cmp(nm, "b", {7'd0, b1}, {7'd0, e.b});
                cmp(nm, "busy", {7'd0, busy1}, {7'd0, e.busy});
                cmp(nm, "err", {7'd0, err1}, {7'd0, e.err});
            end
        end
    end

    // One clock of stimulus to instance s, plus the outputs expected after the edge.
    task automatic step(input logic s, input logic r, input logic ld, input logic [7:0] di,
                        input logic dd, input logic [7:0] eq, input logic eb,
                        input logic ebusy, input logic eerr, input string nm);
        exp_t e;
        @(negedge clk);
        if (s == 1'b0) begin
            rst0 = r; load0 = ld; din0 = di; d0 = dd;
        end else begin
            rst1 = r; load1 = ld; din1 = di; d1 = dd;
        end
        @(posedge clk);
        e.sel = s; e.q = eq; e.b = eb; e.busy = ebusy; e.err = eerr;
        sb.push_back(e);
        names.push_back(nm);
    endtask

    function automatic logic [7:0] to_bcd(input int n);
        logic [7:0] v;
        v[7:4] = 4'(n / 10);
        v[3:0] = 4'(n % 10);
        return v;
    endfunction

    initial begin
        int k;
        // ---------------- instance 0: PRESCALE=1, one-shot ----------------
        step(0, 1, 0, 8'h00, 0, 8'h00, 0, 0, 0, "reset0");
        step(0, 0, 0, 8'h00, 1, 8'h00, 0, 0, 0, "idle_tick");
        // 12 down to 00
        step(0, 0, 1, 8'h12, 0, 8'h12, 0, 1, 0, "load12");
        for (int n = 11; n >= 1; n--)
            step(0, 0, 0, 8'h00, 1, to_bcd(n), 0, 1, 0, "run12");
        step(0, 0, 0, 8'h00, 1, 8'h00, 1, 0, 0, "term12");
        for (int i = 0; i < 5; i++)
            step(0, 0, 0, 8'h00, 1, 8'h00, 0, 0, 0, "done_hold");
        // pause mid-run
        step(0, 0, 1, 8'h05, 0, 8'h05, 0, 1, 0, "load05");
        step(0, 0, 0, 8'h00, 1, 8'h04, 0, 1, 0, "run05");
        step(0, 0, 0, 8'h00, 1, 8'h03, 0, 1, 0, "run05");
        for (int i = 0; i < 4; i++)
            step(0, 0, 0, 8'h00, 0, 8'h03, 0, 1, 0, "pause");
        step(0, 0, 0, 8'h00, 1, 8'h02, 0, 1, 0, "resume");
        step(0, 0, 0, 8'h00, 1, 8'h01, 0, 1, 0, "resume");
        step(0, 0, 0, 8'h00, 1, 8'h00, 1, 0, 0, "term05");
        step(0, 0, 0, 8'h00, 1, 8'h00, 0, 0, 0, "b_single");
        // invalid load while running, then zero load
        step(0, 0, 1, 8'h07, 0, 8'h07, 0, 1, 0, "load07");
        step(0, 0, 1, 8'h1A, 0, 8'h07, 0, 1, 1, "bad_load");
        step(0, 0, 0, 8'h00, 1, 8'h06, 0, 1, 0, "after_bad");
        step(0, 0, 0, 8'h00, 1, 8'h05, 0, 1, 0, "after_bad");
        step(0, 0, 1, 8'h00, 1, 8'h00, 0, 0, 0, "load00");
        step(0, 0, 0, 8'h00, 1, 8'h00, 0, 0, 0, "done00");
        step(0, 0, 1, 8'hA3, 0, 8'h00, 0, 0, 1, "bad_hi");
        step(0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, "err_single");
        // load beats a due tick; borrow across digits
        step(0, 0, 1, 8'h40, 0, 8'h40, 0, 1, 0, "load40");
        step(0, 0, 1, 8'h25, 1, 8'h25, 0, 1, 0, "load_vs_tick");
        step(0, 0, 0, 8'h00, 1, 8'h24, 0, 1, 0, "run25");
        step(0, 0, 1, 8'h40, 0, 8'h40, 0, 1, 0, "load40b");
        step(0, 0, 0, 8'h00, 1, 8'h39, 0, 1, 0, "borrow40");
        // reset mid-run
        step(0, 0, 1, 8'h17, 0, 8'h17, 0, 1, 0, "load17");
        step(0, 1, 0, 8'h00, 1, 8'h00, 0, 0, 0, "reset_run");
        step(0, 0, 0, 8'h00, 1, 8'h00, 0, 0, 0, "idle_after_rst");
        step(0, 0, 1, 8'h33, 1, 8'h33, 0, 1, 0, "load33");
        step(0, 1, 1, 8'h44, 1, 8'h00, 0, 0, 0, "rst_over_load");

        // ---------------- instance 1: PRESCALE=3, auto-reload ----------------
        step(1, 1, 0, 8'h00, 0, 8'h00, 0, 0, 0, "reset1");
        step(1, 0, 1, 8'h03, 0, 8'h03, 0, 1, 0, "load03");
        for (int s = 1; s <= 18; s++) begin
            k = 3 - ((s / 3) % 3);
            step(1, 0, 0, 8'h00, 1, to_bcd(k), ((s % 9) == 0), 1, 0, "reload_run");
        end
        // prescaler holds while paused
        step(1, 0, 0, 8'h00, 1, 8'h03, 0, 1, 0, "pre1");
        step(1, 0, 0, 8'h00, 0, 8'h03, 0, 1, 0, "pre_hold");
        step(1, 0, 0, 8'h00, 0, 8'h03, 0, 1, 0, "pre_hold");
        step(1, 0, 0, 8'h00, 1, 8'h03, 0, 1, 0, "pre2");
        step(1, 0, 0, 8'h00, 1, 8'h02, 0, 1, 0, "pre_wrap");
        // loaded 10 borrows to 09 after three ticks
        step(1, 0, 1, 8'h10, 0, 8'h10, 0, 1, 0, "load10");
        step(1, 0, 0, 8'h00, 1, 8'h10, 0, 1, 0, "tick10");
        step(1, 0, 0, 8'h00, 1, 8'h10, 0, 1, 0, "tick10");
        step(1, 0, 0, 8'h00, 1, 8'h09, 0, 1, 0, "borrow10");

        @(negedge clk);
        load0 = 0; d0 = 0; load1 = 0; d1 = 0;
        for (int i = 0; i < 10 && sb.size() > 0; i++)
            @(posedge clk);
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
